// File: rtl/sim_run_controller_if.sv
// Harness-facing bundle of the run sequencer: run budget/dump controls in, DUT reset and run status out.
interface sim_run_controller_if #(
  parameter int unsigned CW = 64
) ();
  logic [CW-1:0] max_cycles;
  logic [CW-1:0] dump_start_cycle;
  logic          dut_done;
  logic          dut_fail;
  logic          dut_reset;
  logic [CW-1:0] cycle_count;
  logic          dump_en;
  logic          finish;
  logic          finish_pulse;
  logic [1:0]    status;

  modport master (
    output max_cycles, dump_start_cycle, dut_done, dut_fail,
    input  dut_reset, cycle_count, dump_en, finish, finish_pulse, status
  );

  modport slave (
    input  max_cycles, dump_start_cycle, dut_done, dut_fail,
    output dut_reset, cycle_count, dump_en, finish, finish_pulse, status
  );
endinterface

// File: rtl/sim_run_controller.sv
// Run sequencer: DUT reset sequencing, cycle counting, timeout, pass/fail capture,
// dump gating and a drained finish request for the simulation harness.
module sim_run_controller #(
  parameter int unsigned CW           = 64,
  parameter int unsigned RESET_CYCLES = 10,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  sim_run_controller_if.slave  bus
);

  localparam int unsigned HW = 8;
  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 2);

  localparam logic [1:0] STAT_RUNNING = 2'b00;
  localparam logic [1:0] STAT_PASS    = 2'b01;
  localparam logic [1:0] STAT_FAIL    = 2'b10;
  localparam logic [1:0] STAT_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [CW-1:0] cycle_count_q, cycle_count_d;
  logic [1:0]    status_q, status_d;
  logic          dut_reset_q, dut_reset_d;
  logic          dump_en_q, dump_en_d;
  logic          finish_q, finish_d;
  logic          finish_pulse_q, finish_pulse_d;

  logic [1:0]    end_status_c;
  logic          timeout_c;
  logic [HW-1:0] hold_inc_c;
  logic          drain_last_c;

  // Budget of zero disables the timeout entirely.
  assign timeout_c    = (bus.max_cycles != '0) && (cycle_count_q >= bus.max_cycles);
  assign hold_inc_c   = hold_q + HW'(1);
  assign drain_last_c = (({1'b0, drain_q} + (DW+1)'(1)) >= (DW+1)'(DRAIN_CYCLES));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_HOLD;
      hold_q         <= '0;
      drain_q        <= '0;
      cycle_count_q  <= '0;
      status_q       <= STAT_RUNNING;
      dut_reset_q    <= 1'b1;
      dump_en_q      <= 1'b0;
      finish_q       <= 1'b0;
      finish_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      drain_q        <= drain_d;
      cycle_count_q  <= cycle_count_d;
      status_q       <= status_d;
      dut_reset_q    <= dut_reset_d;
      dump_en_q      <= dump_en_d;
      finish_q       <= finish_d;
      finish_pulse_q <= finish_pulse_d;
    end
  end

  // Next-state: fail beats done beats timeout; timeout can also cut HOLD short.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    drain_d      = drain_q;
    end_status_c = STAT_RUNNING;
    case (state_q)
      ST_HOLD: begin
        hold_d = hold_inc_c;
        if (timeout_c) begin
          state_d      = ST_DRAIN;
          end_status_c = STAT_TIMEOUT;
        end else if (hold_inc_c == HW'(RESET_CYCLES)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.dut_fail) begin
          state_d      = ST_DRAIN;
          end_status_c = STAT_FAIL;
        end else if (bus.dut_done) begin
          state_d      = ST_DRAIN;
          end_status_c = STAT_PASS;
        end else if (timeout_c) begin
          state_d      = ST_DRAIN;
          end_status_c = STAT_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DW'(1);
        if (drain_last_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  // Registered outputs derived from the current and next state.
  always_comb begin
    cycle_count_d  = cycle_count_q;
    status_d       = status_q;
    dut_reset_d    = dut_reset_q;
    dump_en_d      = 1'b0;
    finish_d       = 1'b0;
    finish_pulse_d = 1'b0;

    if ((state_q != ST_DONE) && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + CW'(1);
    end

    if ((state_q != ST_DRAIN) && (state_d == ST_DRAIN)) begin
      status_d = end_status_c;
    end

    if ((state_q == ST_HOLD) && (state_d == ST_RUN)) begin
      dut_reset_d = 1'b0;
    end

    finish_d       = (state_d == ST_DONE);
    finish_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);

    // Sticky once started so a moving start cycle cannot chop the dump.
    dump_en_d = (state_d != ST_DONE) &&
                (dump_en_q || (cycle_count_d >= bus.dump_start_cycle));
  end

  assign bus.dut_reset    = dut_reset_q;
  assign bus.cycle_count  = cycle_count_q;
  assign bus.status       = status_q;
  assign bus.dump_en      = dump_en_q;
  assign bus.finish       = finish_q;
  assign bus.finish_pulse = finish_pulse_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: event-level run model checked every cycle,
// plus hand-computed checkpoints from the run scenarios.
module tb_sim_run_controller;
  localparam int unsigned CW   = 64;
  localparam int unsigned RC   = 10;
  localparam int unsigned DC   = 4;
  localparam int unsigned DEFF = (DC == 0) ? 1 : DC;

  logic clk = 1'b0;
  logic rst_n;
  logic cmp_en = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sim_run_controller_if #(.CW(CW)) bus ();

  sim_run_controller #(
    .CW(CW), .RESET_CYCLES(RC), .DRAIN_CYCLES(DC)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Run model: tracks how the run ended and when, and derives outputs arithmetically.
  logic [63:0] m_cnt, m_end_at, m_pre;
  logic        m_ended, m_dut_reset, m_finish, m_pulse, m_dump, m_fin;
  logic [1:0]  m_status, m_code;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_end_at = 0; m_ended = 0; m_status = 0;
      m_dut_reset = 1; m_finish = 0; m_pulse = 0; m_dump = 0;
    end else if (m_finish) begin
      m_pulse = 0;
    end else begin
      m_pre = m_cnt;
      if (!m_ended) begin
        m_code = 2'd0;
        if (!m_dut_reset && bus.dut_fail)      m_code = 2'd2;
        else if (!m_dut_reset && bus.dut_done) m_code = 2'd1;
        else if (bus.max_cycles != 0 && m_pre >= bus.max_cycles) m_code = 2'd3;
        if (m_code != 2'd0) begin
          m_ended = 1; m_status = m_code; m_end_at = m_pre + 1;
        end else if (m_dut_reset && (m_pre + 1 == 64'(RC))) begin
          m_dut_reset = 0;
        end
      end
      m_cnt    = (m_pre == '1) ? m_pre : m_pre + 1;
      m_fin    = m_ended && (m_cnt >= m_end_at + 64'(DEFF));
      m_pulse  = m_fin;
      m_finish = m_fin;
      m_dump   = !m_fin && (m_dump || (m_cnt >= bus.dump_start_cycle));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("dut_reset",    64'(bus.dut_reset),    64'(m_dut_reset));
      check("cycle_count",  bus.cycle_count,       m_cnt);
      check("status",       64'(bus.status),       64'(m_status));
      check("dump_en",      64'(bus.dump_en),      64'(m_dump));
      check("finish",       64'(bus.finish),       64'(m_finish));
      check("finish_pulse", 64'(bus.finish_pulse), 64'(m_pulse));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_count(input logic [63:0] n, input string name);
    int budget = 2000;
    while (bus.cycle_count != n && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: cycle_count 0x%0h never reached 0x%0h", name, bus.cycle_count, n);
    end
  endtask

  task automatic wait_finish(input string name);
    int budget = 50;
    while (!bus.finish && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: finish never rose, cycle_count 0x%0h", name, bus.cycle_count);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.max_cycles = '0;
    bus.dump_start_cycle = '0;
    bus.dut_done = 1'b0;
    bus.dut_fail = 1'b0;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    #1;
    check("rst_dut_reset", 64'(bus.dut_reset), 64'd1);
    check("rst_count",     bus.cycle_count,    64'd0);
    check("rst_status",    64'(bus.status),    64'd0);
    check("rst_finish",    64'(bus.finish),    64'd0);
    check("rst_dump",      64'(bus.dump_en),   64'd0);

    // Idle DUT, no budget: reset sequence then an endless run.
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 30 && bus.dut_reset; i++) step();
    check("run_entry_count", bus.cycle_count, 64'd10);
    check("run_entry_dutrst", 64'(bus.dut_reset), 64'd0);
    wait_count(64'd1000, "idle_run");
    check("idle_finish", 64'(bus.finish), 64'd0);
    check("idle_status", 64'(bus.status), 64'd0);

    // Pass with dump window starting at 30.
    bus.dump_start_cycle = 64'd30;
    do_reset();
    wait_count(64'd29, "dump_pre");
    check("dump_at29", 64'(bus.dump_en), 64'd0);
    step();
    check("dump_at30_count", bus.cycle_count, 64'd30);
    check("dump_at30", 64'(bus.dump_en), 64'd1);
    wait_count(64'd50, "pass_wait");
    bus.dut_done = 1'b1;
    step();
    bus.dut_done = 1'b0;
    check("pass_status", 64'(bus.status), 64'd1);
    check("pass_count",  bus.cycle_count, 64'd51);
    check("pass_drain_dump", 64'(bus.dump_en), 64'd1);
    wait_finish("pass_finish");
    check("pass_fin_count", bus.cycle_count, 64'd55);
    check("pass_pulse_hi", 64'(bus.finish_pulse), 64'd1);
    check("pass_done_dump", 64'(bus.dump_en), 64'd0);
    step();
    check("pass_pulse_lo", 64'(bus.finish_pulse), 64'd0);
    check("pass_finish_sticky", 64'(bus.finish), 64'd1);
    check("pass_frozen", bus.cycle_count, 64'd55);

    // Timeout at 100 with a silent DUT.
    bus.dump_start_cycle = '0;
    bus.max_cycles = 64'd100;
    do_reset();
    wait_count(64'd100, "to_wait");
    check("to_pre_status", 64'(bus.status), 64'd0);
    step();
    check("to_status", 64'(bus.status), 64'd3);
    check("to_count", bus.cycle_count, 64'd101);
    wait_count(64'd104, "to_drain");
    check("to_drain_dump", 64'(bus.dump_en), 64'd1);
    check("to_drain_finish", 64'(bus.finish), 64'd0);
    step();
    check("to_finish", 64'(bus.finish), 64'd1);
    check("to_fin_dump", 64'(bus.dump_en), 64'd0);
    check("to_fin_count", bus.cycle_count, 64'd105);

    // Fail, done and timeout all on one edge: fail wins.
    bus.max_cycles = 64'd60;
    do_reset();
    wait_count(64'd60, "prio_wait");
    bus.dut_done = 1'b1;
    bus.dut_fail = 1'b1;
    step();
    bus.dut_done = 1'b0;
    bus.dut_fail = 1'b0;
    check("prio_status", 64'(bus.status), 64'd2);

    // Mid-run reset, then a rerun ended by lowering the budget below the count.
    bus.max_cycles = '0;
    do_reset();
    wait_count(64'd40, "midrst_wait");
    rst_n = 1'b0;
    #1;
    check("midrst_dutrst", 64'(bus.dut_reset), 64'd1);
    check("midrst_count",  bus.cycle_count,    64'd0);
    check("midrst_status", 64'(bus.status),    64'd0);
    check("midrst_dump",   64'(bus.dump_en),   64'd0);
    step(); step();
    rst_n = 1'b1;
    wait_count(64'd80, "lower_wait");
    bus.max_cycles = 64'd20;
    step();
    check("lower_status", 64'(bus.status), 64'd3);
    check("lower_count", bus.cycle_count, 64'd81);
    bus.max_cycles = '0;
    wait_finish("lower_finish");
    check("lower_fin_count", bus.cycle_count, 64'd85);

    // Budget shorter than the reset sequence: timeout inside HOLD.
    bus.max_cycles = 64'd5;
    do_reset();
    wait_count(64'd5, "hold_wait");
    check("hold_pre_status", 64'(bus.status), 64'd0);
    step();
    check("hold_status", 64'(bus.status), 64'd3);
    check("hold_dutrst", 64'(bus.dut_reset), 64'd1);
    wait_finish("hold_finish");
    check("hold_fin_count", bus.cycle_count, 64'd10);
    check("hold_fin_dutrst", 64'(bus.dut_reset), 64'd1);
    step();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
